// File: rtl/shift_seq_ctrl_if.sv
// Command channel between an upstream command source and shift_seq_ctrl.
// The master issues a command with a valid/ready handshake and the slave accepts it.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_amount;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_amount, cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amount, cmd_data, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a universal shift-register array built from mux+DFF cells.
// It takes one command at a time (load, shift right, shift left, rotate right by N).
// It then steps the array's shared select lines one cycle per position and finally
// pulses done. For rotate, sr_in is wired straight from the array LSB so that every
// step reinserts the bit that is currently leaving.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  shift_seq_ctrl_if.slave  cmd,
  input  logic [WIDTH-1:0] q_fb,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] load_data,
  output logic             sr_in,
  output logic             sl_in,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_ROR   = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sr_fill;
  logic             rot_run;
  logic             unused_fb;

  // A command can only be taken in IDLE, and never while reset is being applied.
  assign cmd.cmd_ready = (state == IDLE) && !CLR;

  // Rotate feeds the MSB from the live LSB; otherwise the registered fill bit is used.
  assign sr_in = rot_run ? q_fb[0] : sr_fill;

  // Only the LSB of the feedback word matters to this controller.
  assign unused_fb = ^q_fb[WIDTH-1:1];

  // Sequencer: accept, then step the array once per cycle, then pulse done.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= SEL_HOLD;
      load_data <= '0;
      sr_fill   <= 1'b0;
      sl_in     <= 1'b0;
      rot_run   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd.cmd_valid) begin
            if (cmd.cmd_op == OP_LOAD) begin
              state     <= RUN;
              cnt       <= '0;
              sel       <= SEL_LOAD;
              load_data <= cmd.cmd_data;
              busy      <= 1'b1;
            end else if (cmd.cmd_amount == '0) begin
              state <= DONE;
              sel   <= SEL_HOLD;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              cnt     <= cmd.cmd_amount - CNT_W'(1);
              sel     <= (cmd.cmd_op == OP_SHL) ? SEL_SHL : SEL_SHR;
              sr_fill <= (cmd.cmd_op == OP_SHR) ? cmd.cmd_fill : 1'b0;
              sl_in   <= (cmd.cmd_op == OP_SHL) ? cmd.cmd_fill : 1'b0;
              rot_run <= (cmd.cmd_op == OP_ROR);
              busy    <= 1'b1;
            end
          end
        end

        RUN: begin
          if (cnt == '0) begin
            state   <= DONE;
            sel     <= SEL_HOLD;
            sr_fill <= 1'b0;
            sl_in   <= 1'b0;
            rot_run <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          sel   <= SEL_HOLD;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a behavioural 4-bit array closes the loop through q_fb.
// A timing model (cycles since acceptance) predicts every control output each cycle,
// and the final array contents are checked against hand literals and an arithmetic model.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             CLR;
  logic [WIDTH-1:0] q_fb;
  logic [1:0]       sel;
  logic [WIDTH-1:0] load_data;
  logic             sr_in;
  logic             sl_in;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] q_arr = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_cmd = 0;
  bit         m_rst_seen = 0;
  bit         m_after_clr = 0;
  int         m_j = 0;
  int         m_len = 0;
  int         m_accepts = 0;
  logic [1:0] m_op = 2'b00;
  logic       m_fill = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .cmd       (cmd.slave),
    .q_fb      (q_fb),
    .sel       (sel),
    .load_data (load_data),
    .sr_in     (sr_in),
    .sl_in     (sl_in),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  assign q_fb = q_arr;

  // The controlled array: hold, shift right, shift left or parallel load.
  always @(posedge CLK) begin
    case (sel)
      2'b01:   q_arr <= {sr_in, q_arr[WIDTH-1:1]};
      2'b10:   q_arr <= {q_arr[WIDTH-2:0], sl_in};
      2'b11:   q_arr <= load_data;
      default: q_arr <= q_arr;
    endcase
  end

  // Timing model: a command occupies len active cycles, then one done cycle.
  always @(posedge CLK) begin
    m_after_clr = CLR;
    if (CLR) begin
      m_cmd      = 0;
      m_j        = 0;
      m_rst_seen = 1;
    end else if (m_rst_seen) begin
      if (!m_cmd) begin
        if (cmd.cmd_valid) begin
          m_cmd  = 1;
          m_j    = 1;
          m_op   = cmd.cmd_op;
          m_fill = cmd.cmd_fill;
          m_data = cmd.cmd_data;
          m_len  = (cmd.cmd_op == 2'b00) ? 1 : int'(cmd.cmd_amount);
          m_accepts++;
        end
      end else if (m_j == m_len + 1) begin
        m_cmd = 0;
      end else begin
        m_j++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the array must hold after a command, straight from the shift/rotate rules.
  function automatic logic [WIDTH-1:0] arrAfter(input logic [WIDTH-1:0] q, input logic [1:0] op,
                                                 input int k, input logic fill,
                                                 input logic [WIDTH-1:0] d);
    int v, m, f, kk;
    v = int'(q);
    m = (1 << WIDTH) - 1;
    case (op)
      2'b00: return d;
      2'b01: begin
        if (k >= WIDTH) return fill ? WIDTH'(m) : '0;
        f = fill ? (m & ~(m >> k)) : 0;
        return WIDTH'((v >> k) | f);
      end
      2'b10: begin
        if (k >= WIDTH) return fill ? WIDTH'(m) : '0;
        f = fill ? ((1 << k) - 1) : 0;
        return WIDTH'(((v << k) & m) | f);
      end
      default: begin
        kk = k % WIDTH;
        return WIDTH'(((v >> kk) | (v << (WIDTH - kk))) & m);
      end
    endcase
  endfunction

  // Per-cycle compare of every control output against the timing model.
  always @(negedge CLK) begin
    if (m_rst_seen) begin
      automatic bit         in_run  = m_cmd && (m_j <= m_len);
      automatic bit         in_done = m_cmd && (m_j == m_len + 1);
      automatic logic [1:0] e_sel   = 2'b00;
      automatic logic       e_sr    = 1'b0;
      automatic logic       e_sl    = 1'b0;
      if (in_run) begin
        e_sel = (m_op == 2'b00) ? 2'b11 : (m_op == 2'b11) ? 2'b01 : m_op;
        if (m_op == 2'b01) e_sr = m_fill;
        if (m_op == 2'b11) e_sr = q_arr[0];
        if (m_op == 2'b10) e_sl = m_fill;
      end
      checkOutput("sel", 8'(sel), 8'(e_sel));
      checkOutput("busy", 8'(busy), 8'(in_run));
      checkOutput("done", 8'(done), 8'(in_done));
      checkOutput("cmd_ready", 8'(cmd.cmd_ready), 8'(!CLR && !m_cmd));
      checkOutput("sr_in", 8'(sr_in), 8'(e_sr));
      checkOutput("sl_in", 8'(sl_in), 8'(e_sl));
      if (in_run && m_op == 2'b00) checkOutput("load_data", 8'(load_data), 8'(m_data));
      if (m_after_clr) checkOutput("load_data_rst", 8'(load_data), 8'h00);
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (m_cmd && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (m_cmd) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL idle_timeout: got busy, expected idle at %0t", $time);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] op, input int k,
                               input logic [WIDTH-1:0] d, input logic fill,
                               input logic [WIDTH-1:0] exp_lit);
    int start, n;
    logic [WIDTH-1:0] q0;
    q0             = q_arr;
    start          = m_accepts;
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = op;
    cmd.cmd_amount = CNT_W'(k);
    cmd.cmd_data   = d;
    cmd.cmd_fill   = fill;
    n = 0;
    while (m_accepts == start && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    cmd.cmd_valid = 1'b0;
    if (m_accepts == start) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_accept: got no acceptance, expected one at %0t", name, $time);
    end
    waitIdle();
    checkOutput({name, "_arr_lit"}, 8'(q_arr), 8'(exp_lit));
    checkOutput({name, "_arr_model"}, 8'(q_arr), 8'(arrAfter(q0, op, k, fill, d)));
  endtask

  initial begin
    int start, n;
    CLR            = 1'b1;
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = 2'b00;
    cmd.cmd_amount = '0;
    cmd.cmd_data   = 4'b0101;
    cmd.cmd_fill   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    CLR           = 1'b0;
    cmd.cmd_valid = 1'b0;
    @(posedge CLK);
    #1;

    applyStimulus("load",    2'b00, 0, 4'b1011, 1'b0, 4'b1011);
    applyStimulus("shr2",    2'b01, 2, 4'b0000, 1'b1, 4'b1110);
    applyStimulus("shl0",    2'b10, 0, 4'b0000, 1'b1, 4'b1110);
    applyStimulus("reload",  2'b00, 0, 4'b1011, 1'b0, 4'b1011);
    applyStimulus("ror5",    2'b11, 5, 4'b0000, 1'b0, 4'b1101);
    applyStimulus("shl6",    2'b10, 6, 4'b0000, 1'b0, 4'b0000);
    applyStimulus("shr7",    2'b01, 7, 4'b0000, 1'b1, 4'b1111);
    applyStimulus("ror3",    2'b11, 3, 4'b0000, 1'b0, 4'b1111);
    applyStimulus("load2",   2'b00, 0, 4'b1001, 1'b0, 4'b1001);
    applyStimulus("ror1",    2'b11, 1, 4'b0000, 1'b0, 4'b1100);

    // cmd_valid held high across two shift-left-by-1 commands
    start          = m_accepts;
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = 2'b10;
    cmd.cmd_amount = CNT_W'(1);
    cmd.cmd_fill   = 1'b1;
    n = 0;
    while (m_accepts < start + 2 && n < 30) begin
      @(posedge CLK);
      #1;
      n++;
    end
    cmd.cmd_valid = 1'b0;
    waitIdle();
    checkOutput("held_valid_accepts", 8'(m_accepts - start), 8'd2);
    checkOutput("held_valid_arr", 8'(q_arr), 8'b0011);

    // reset in the second cycle of a four-step shift aborts it without done
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = 2'b01;
    cmd.cmd_amount = CNT_W'(4);
    cmd.cmd_fill   = 1'b0;
    start = m_accepts;
    n = 0;
    while (m_accepts == start && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    cmd.cmd_valid = 1'b0;
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    checkOutput("abort_sel", 8'(sel), 8'h00);
    checkOutput("abort_done", 8'(done), 8'h00);
    applyStimulus("load_after_abort", 2'b00, 0, 4'b0110, 1'b0, 4'b0110);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command sequencer sitting directly upstream of a WIDTH-bit universal shift register built from per-bit mux+DFF cells.
- Accepts one command at a time over a valid/ready handshake: parallel load, shift right, shift left, or rotate right, each by N positions.
- Drives the array's shared 2-bit select, parallel-load word and serial-fill bits cycle by cycle, then reports completion.

Parameters:
- WIDTH, 4, bit count of the controlled shift-register array.
- CNT_W, 3, width of the shift-amount field and internal step counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 load, 01 shift right, 10 shift left, 11 rotate right.
- cmd_amount  in  CNT_W  number of shift/rotate steps; ignored for load.
- cmd_data  in  WIDTH  parallel word for load.
- cmd_fill  in  1  bit shifted in for shift right/left.
- q_fb  in  WIDTH  current array contents, fed back for rotate.
- sel  out  2  array select: 00 hold, 01 shift right, 10 shift left, 11 load.
- load_data  out  WIDTH  parallel word presented to the array.
- sr_in  out  1  serial input entering the MSB on shift right.
- sl_in  out  1  serial input entering the LSB on shift left.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (CLR high at an edge): state IDLE, sel=00, load_data=0, sr_in=0, sl_in=0, busy=0, done=0, counter=0. cmd_ready is 0 while CLR is high.
- Reset mid-command aborts it. sel returns to 00 on the same edge, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, sel=00.
  - Acceptance happens when cmd_valid & cmd_ready are high at an edge.
  - The edge that accepts a command captures op, amount, data and fill into registers.
- Load: next state RUN with a step count of 1. load_data is the captured cmd_data and sel=11 for exactly one cycle, then DONE.
- Shift/rotate with amount k>0: RUN for exactly k cycles with sel = op code (rotate uses sel=01).
- Counter loads k-1 on acceptance, decrements each RUN cycle and exits to DONE when it reads 0.
- Shift with amount 0: go directly from IDLE to DONE. sel never leaves 00.
- Serial inputs:
  - Shift right: sr_in=fill.
  - Shift left: sl_in=fill.
  - Rotate right: sr_in=q_fb[0], combinational from q_fb, so each step reinserts the current LSB.
  - Unused serial input is held 0.
- Amounts above WIDTH are legal. A shift saturates the array to all fill bits; a rotate wraps modulo WIDTH.
- DONE: sel=00, done=1 for exactly one cycle, busy=0, cmd_ready=0. Next state IDLE.
- busy=1 in RUN only.
- Timing: acceptance at edge t gives sel active in cycles t+1..t+k and done in cycle t+k+1. The earliest next acceptance is edge t+k+2.
- cmd_valid held high through DONE is not accepted until IDLE. Inputs other than q_fb are ignored outside the acceptance edge.
- All outputs except cmd_ready and sr_in during rotate are registered.

Test Plan:
- Reset: CLR=1 for 2 cycles with cmd_valid=1 -> sel=00, busy=0, done=0, cmd_ready=0; ready rises on the first cycle after CLR drops.
- Load 4'b1011 -> sel=11 for 1 cycle with load_data=1011; done next cycle; array model reads 1011.
- Shift right k=2, fill=1 from 1011 -> sel=01 for exactly 2 cycles, sr_in=1; array model reads 1110; done 3 cycles after acceptance.
- Shift left k=0 -> no sel activity, done on the cycle after acceptance; array unchanged.
- Rotate right k=5 from 1011 (WIDTH=4) -> 5 cycles sel=01, sr_in tracks q_fb[0]; array model reads 1101.
- CLR asserted during cycle 2 of a k=4 shift -> sel=00 next cycle, no done pulse; a new load command is then accepted and completes correctly.
